// File: rtl/seq_detect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : seq_detect_pkg                                               |
// | Description : Shared types and helpers for the parametrised serial         |
// |               pattern detector: FSM state encoding and the legality        |
// |               check applied to a requested pattern length.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seq_detect_pkg;

   // IDLE: no valid configuration, input ignored. RUN: detecting.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // A pattern length is usable when it selects at least one bit and
   // no more bits than the history window provides.
   function automatic logic len_is_legal(input int unsigned len,
                                         input int unsigned max_len);
      return (len >= 32'd1) && (len <= max_len);
   endfunction

endpackage : seq_detect_pkg
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_detect_param                                             |
// | Description : Serial pattern detector with a runtime-programmable pattern  |
// |               of 1..PAT_W bits, overlapping / non-overlapping matching,    |
// |               qualified input, saturating match counter and a small        |
// |               configuration state machine.                                 |
// |                                                                            |
// | Ports       : clk, reset (async, active-high)                              |
// |               din, din_valid      - serial bit and its qualifier           |
// |               cfg_load            - latches pattern / pat_len / overlap    |
// |               pattern, pat_len    - target (MSB of active part first)      |
// |               overlap             - 1: overlapping matches allowed         |
// |               clr_cnt             - synchronous clear of match_cnt         |
// |               dout                - registered 1-clk match pulse           |
// |               led                 - masked pattern while dout is high      |
// |               match_cnt           - saturating match count                 |
// |               armed               - high in RUN                            |
// |               cfg_err             - sticky illegal-length flag             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter  int PAT_W = 8,
   parameter  int CNT_W = 8,
   localparam int LEN_W = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             dout,
   output logic [PAT_W-1:0] led,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed,
   output logic             cfg_err
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   state_t            r_state;
   logic [PAT_W-1:0]  r_pat;
   logic [LEN_W-1:0]  r_len;
   logic              r_ovl;
   // Only PAT_W-1 past bits are stored: together with the incoming bit
   // they form the full PAT_W-bit comparison window.
   logic [PAT_W-2:0]  r_hist;
   logic [LEN_W-1:0]  r_fill;
   logic              r_dout;
   logic [PAT_W-1:0]  r_led;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;

   logic [PAT_W-1:0]  w_mask;
   logic [PAT_W-1:0]  w_window;
   logic              w_cfg_ok;
   logic              w_consume;
   logic              w_fill_ok;
   logic              w_match;

   // Compare / mask logic. The window is the history with the current bit
   // appended at the LSB, so pattern[0] lines up with the newest bit.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (LEN_W'(i) < r_len);
      end
      w_window  = {r_hist, din};
      w_cfg_ok  = len_is_legal(32'(pat_len), PAT_W);
      // A cfg_load in RUN drops any bit offered in the same cycle.
      w_consume = din_valid & (r_state == ST_RUN) & ~cfg_load;
      // Enough bits seen once this one is counted; fill gates out stale history.
      w_fill_ok = (({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len});
      w_match   = w_consume & w_fill_ok &
                  (((w_window ^ r_pat) & w_mask) == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_pat   <= '0;
         r_len   <= '0;
         r_ovl   <= 1'b0;
         r_hist  <= '0;
         r_fill  <= '0;
         r_dout  <= 1'b0;
         r_led   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_dout <= w_match;
         r_led  <= w_match ? (r_pat & w_mask) : '0;

         // Clear has priority over a coincident match.
         if (clr_cnt) begin
            r_cnt <= '0;
         end else if (w_match && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (cfg_load) begin
                  if (w_cfg_ok) begin
                     r_pat   <= pattern;
                     r_len   <= pat_len;
                     r_ovl   <= overlap;
                     r_hist  <= '0;
                     r_fill  <= '0;
                     r_state <= ST_RUN;
                  end else begin
                     r_err   <= 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (cfg_load) begin
                  if (w_cfg_ok) begin
                     r_pat   <= pattern;
                     r_len   <= pat_len;
                     r_ovl   <= overlap;
                     r_hist  <= '0;
                     r_fill  <= '0;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end else if (w_consume) begin
                  r_hist <= w_window[PAT_W-2:0];
                  if (w_match && !r_ovl) begin
                     // Non-overlapping: restart the count, old history is
                     // masked out by fill until enough new bits arrive.
                     r_fill <= '0;
                  end else if (r_fill < r_len) begin
                     r_fill <= r_fill + LEN_W'(1);
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dout      = r_dout;
   assign led       = r_led;
   assign match_cnt = r_cnt;
   assign armed     = (r_state == ST_RUN);
   assign cfg_err   = r_err;

endmodule : seq_detect_param
`default_nettype wire
